// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, baud-rate selection and receive FIFO sizing.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      BAUD_4800  = 2'd0,
      BAUD_9600  = 2'd1,
      BAUD_19200 = 2'd2,
      BAUD_38400 = 2'd3
   } baud_sel_t;

   localparam int RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read port and registered
// count/empty/full. Pushes into a full FIFO are accepted only alongside a pop.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == FULL_CNT);
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: rising-edge capture of rx_status,
// sticky overflow flag, and optional saturating drop counter (UART_RX_OVF_CNT_EN).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic                   rx_status,
   input  logic [WIDTH-1:0]       rx_byte,
   input  logic                   rd_en,
   input  logic                   clr_ovf,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
`ifdef UART_RX_OVF_CNT_EN
   output logic [7:0]             ovf_count,
`endif
   output logic                   overflow
);

   logic rx_status_q;
   logic push;
   logic drop;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rx_status_q <= 1'b0;
      end else begin
         rx_status_q <= rx_status;
      end
   end

   assign push = rx_status & ~rx_status_q;
   // A full FIFO still accepts the byte if a pop frees a slot in the same cycle.
   assign drop = push & full & ~(rd_en & ~empty);

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .sys_clk (sys_clk),
      .rst     (rst),
      .push    (push),
      .pop     (rd_en),
      .wr_data (rx_byte),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef UART_RX_OVF_CNT_EN
   // A drop coinciding with clr_ovf restarts the count at one.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ovf_count <= 8'd0;
      end else if (drop) begin
         if (clr_ovf)                ovf_count <= 8'd1;
         else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end else if (clr_ovf) begin
         ovf_count <= 8'd0;
      end
   end
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver in `uart_top`. It captures each byte the receiver reports via `rx_status`/`RHR` into a synchronous FIFO, so software or LED/display logic can drain bytes at its own pace without losing back-to-back characters. It presents a first-word-fall-through read port with occupancy flags and a sticky overflow indication.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, at least 2.
- `WIDTH`, 8: data width in bits.
- `sys_clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_status` input 1: receiver byte-ready level; each low-to-high transition marks one new byte.
- `rx_byte` input WIDTH: receiver holding register (`RHR`); valid when `rx_status` rises.
- `rd_en` input 1: pop the head entry this cycle.
- `clr_ovf` input 1: clear the sticky overflow flag.
- `rd_data` output WIDTH: head entry (FWFT); valid only while `empty`=0.
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds DEPTH entries.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `ovf_count` output 8: saturating dropped-byte counter (present only with `UART_RX_OVF_CNT_EN`).

Clock is one domain, `sys_clk`; reset is synchronous and active-high on `rst`.

## Operation
- Edge detect: register `rx_status_q`. `push = rx_status & ~rx_status_q`. Sample `rx_byte` in the same cycle as `push`. A level held high produces exactly one push.
- Storage: DEPTH x WIDTH array. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is held separately as a registered value.
- `pop = rd_en & ~empty`. A `rd_en` asserted while `empty`=1 is ignored and does not alter state.
- `push` with `full`=0: write `mem[wr_ptr]`, increment `wr_ptr`.
- `push` with `full`=1 and `pop`=1: pop and push both occur; `count` stays DEPTH.
- `push` with `full`=1 and `pop`=0: byte is dropped; set `overflow`; pointers are unchanged.
- `push` and `pop` together with 0<`count`<DEPTH: both occur; `count` is unchanged.
- `push` with `empty`=1 and `rd_en`=1: only the push takes effect.
- `clr_ovf` clears `overflow`. If `clr_ovf` and a drop occur in the same cycle, the set wins.
- `rd_data = mem[rd_ptr]`, read combinationally. The value is undefined but stable when `empty`=1.

## Timing
- Reset values: `rx_status_q`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `ovf_count`=0. Memory contents are not reset.
- Because `rx_status_q` resets to 0, an `rx_status` held high through reset release produces one push on the first active cycle.
- Write latency: `rx_status` sampled high at edge N (low at N-1) makes the byte visible on `rd_data`, with `empty`=0, after edge N.
- Pop: with `rd_en`=1 at edge N, the next entry (or `empty`=1) appears after edge N.
- `empty`, `full` and `count` are registered and update at the same edge as the pointers.
- Asserting `rst` mid-stream discards all entries at the next edge.

## Configuration
- `UART_RX_OVF_CNT_EN` defined: `ovf_count` is present. It increments on every dropped byte, saturates at 255, and is cleared by `clr_ovf` (an increment in the same cycle wins, giving a value of 1).
- `UART_RX_OVF_CNT_EN` undefined: port and counter are absent; only the sticky `overflow` flag exists.

## Structure
- Shared package `uart_pkg`: `typedef logic [7:0] byte_t`; baud-select enum (4800/9600/19200/38400); default `RX_FIFO_DEPTH`=16.
- Sub-module `uart_sync_fifo`: generic pointer, count and memory logic with push/pop/full/empty.
- `uart_rx_fifo` wraps `uart_sync_fifo` and adds edge detection, drop detection, `overflow` and the optional counter.

## Test plan
- Reset, then pulse `rx_status` with `rx_byte`=0xA5 -> `empty` falls the next cycle, `rd_data`=0xA5, `count`=1; `rd_en` for 1 cycle -> `empty`=1, `count`=0.
- Hold `rx_status` high for 10 cycles with `rx_byte`=0x3C -> exactly one entry stored (`count`=1).
- 16 rising edges carrying 0x00..0x0F -> `full`=1; a 17th edge carrying 0xFF -> `overflow`=1, `count`=16; drain -> 0x00..0x0F in order, and 0xFF is never seen.
- Full FIFO, rising edge and `rd_en` in the same cycle -> `count` stays 16, `overflow` stays 0, new byte is last out; this also exercises pointer wrap.
- Empty FIFO, `rd_en`=1 with no push -> no state change; `rd_en` coincident with the first push -> `count`=1.
- With `UART_RX_OVF_CNT_EN`: 300 drops -> `ovf_count`=255; `clr_ovf` -> 0; `clr_ovf` coincident with a drop -> `overflow`=1, `ovf_count`=1.
